// File: rtl/fp_align_pkg.sv
// Shared types and helpers for the FP adder alignment stage.
// Holds the FSM state encoding, the GRS extension width and the per-cycle shift clamp.
package fp_align_pkg;

  localparam int GRS_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned min_shift(input int unsigned rem, input int unsigned step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Combinational right shift of an extended mantissa by 0..STEP bit positions.
// Latency 0; no flow control. FP_ALIGN_STICKY_EN folds every shifted-out bit into bit 0.
module fp_sticky_shr #(
  parameter int EXT_W = 27,
  parameter int STEP  = 4,
  parameter int SH_W  = $clog2(STEP + 1)
) (
  input  logic [EXT_W-1:0] din,
  input  logic [SH_W-1:0]  sh,
  output logic [EXT_W-1:0] dout
);

  logic [EXT_W-1:0] shifted;

`ifdef FP_ALIGN_STICKY_EN
  logic lost;

  always_comb begin
    shifted = din >> sh;
    lost    = 1'b0;
    // Bits below the shift amount fall off the end; the old bit 0 is among them.
    for (int i = 0; i < EXT_W; i++) begin
      if (i < int'(sh)) lost = lost | din[i];
    end
    dout = {shifted[EXT_W-1:1], shifted[0] | lost};
  end
`else
  always_comb begin
    shifted = din >> sh;
    dout    = shifted;
  end
`endif

endmodule

// File: rtl/fp_align_shift.sv
// Aligns the smaller-exponent mantissa to the larger one, shifting STEP bits per cycle.
// Latency 1 + ceil(min(diff,EXT_W)/STEP); one op in flight, result held until out_ready.
// FP_ALIGN_STICKY_EN: accumulate shifted-out bits into man_small[0] (else truncate).
module fp_align_shift
  import fp_align_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int STEP  = 4,
  localparam int EXT_W = MAN_W + GRS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [EXP_W-1:0] diff,
  input  logic             diff_sign,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [EXT_W-1:0] man_big,
  output logic [EXT_W-1:0] man_small,
  output logic             swap_out
);

  localparam int REM_W = $clog2(EXT_W + 1);
  localparam int SH_W  = $clog2(STEP + 1);

  state_t           state;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_init;
  logic [SH_W-1:0]  step_amt;
  logic [EXT_W-1:0] shr_out;
  logic             diff_sat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Any difference of EXT_W or more pushes every bit out, so clamp there.
  assign diff_sat = 32'(diff) >= 32'(EXT_W);
  assign rem_init = diff_sat ? REM_W'(EXT_W) : REM_W'(diff);
  assign step_amt = SH_W'(min_shift(32'(rem), STEP));

  fp_sticky_shr #(
    .EXT_W (EXT_W),
    .STEP  (STEP),
    .SH_W  (SH_W)
  ) u_shr (
    .din  (man_small),
    .sh   (step_amt),
    .dout (shr_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      exp_out   <= '0;
      man_big   <= '0;
      man_small <= '0;
      swap_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            exp_out   <= diff_sign ? exp_b : exp_a;
            man_big   <= {(diff_sign ? man_b : man_a), {GRS_W{1'b0}}};
            man_small <= {(diff_sign ? man_a : man_b), {GRS_W{1'b0}}};
            swap_out  <= diff_sign;
            rem       <= rem_init;
            state     <= (rem_init == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          man_small <= shr_out;
          rem       <= rem - REM_W'(step_amt);
          if (rem == REM_W'(step_amt)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_shift.sv
// Directed plus random checks of fp_align_shift against an arithmetic alignment model.
module tb_fp_align_shift;

  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int STEP  = 4;
  localparam int EXT_W = MAN_W + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a, exp_b, diff;
  logic             diff_sign;
  logic [MAN_W-1:0] man_a, man_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic [EXT_W-1:0] man_big, man_small;
  logic             swap_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_align_shift #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .diff      (diff),
    .diff_sign (diff_sign),
    .man_a     (man_a),
    .man_b     (man_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .man_big   (man_big),
    .man_small (man_small),
    .swap_out  (swap_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_exp_out"},   64'(exp_out),   64'd0);
    check({tag, "_man_big"},   64'(man_big),   64'd0);
    check({tag, "_man_small"}, 64'(man_small), 64'd0);
    check({tag, "_swap_out"},  64'(swap_out),  64'd0);
  endtask

  // Present one operand pair, wait for the result, compare against the model,
  // then hold off the consumer for 'hold' cycles before releasing it.
  task automatic run_op(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb,
                        input logic [MAN_W-1:0] ma, input logic [MAN_W-1:0] mb,
                        input int hold, input string tag);
    logic        sgn;
    int          d, rem, lat, cyc;
    logic [63:0] big_e, small_e, exp_small, mask;

    sgn     = (ea < eb);
    d       = sgn ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
    big_e   = {37'd0, (sgn ? mb : ma), 3'b000};
    small_e = {37'd0, (sgn ? ma : mb), 3'b000};
    rem     = (d > EXT_W) ? EXT_W : d;
    exp_small = small_e >> rem;
`ifdef FP_ALIGN_STICKY_EN
    mask = (64'd1 << rem) - 64'd1;
    if ((small_e & mask) != 64'd0) exp_small = exp_small | 64'd1;
`else
    mask = 64'd0;
`endif
    lat = 1 + (rem + STEP - 1) / STEP;

    @(negedge clk);
    check({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    exp_a     = ea;
    exp_b     = eb;
    diff      = EXP_W'(d);
    diff_sign = sgn;
    man_a     = ma;
    man_b     = mb;
    out_ready = 1'b0;

    @(negedge clk);
    cyc = 1;
    // Keep in_valid high with different operands while busy; they must not be taken.
    exp_a = EXP_W'($urandom);
    exp_b = EXP_W'($urandom);
    diff  = EXP_W'($urandom);
    man_a = MAN_W'($urandom);
    man_b = MAN_W'($urandom);
    diff_sign = ~sgn;
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"},   64'(cyc),       64'(lat));
    check({tag, "_exp_out"},   64'(exp_out),   64'(sgn ? eb : ea));
    check({tag, "_man_big"},   64'(man_big),   big_e);
    check({tag, "_man_small"}, 64'(man_small), exp_small);
    check({tag, "_swap_out"},  64'(swap_out),  64'(sgn));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
      check({tag, "_hold_small"}, 64'(man_small), exp_small);
      check({tag, "_hold_big"},   64'(man_big),   big_e);
      check({tag, "_hold_exp"},   64'(exp_out),   64'(sgn ? eb : ea));
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_release_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic [EXP_W-1:0] ra, rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_a     = '0;
    exp_b     = '0;
    diff      = '0;
    diff_sign = 1'b0;
    man_a     = '0;
    man_b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    run_op(8'd127, 8'd127, 24'h800000, 24'h800000, 0, "equal_exp");
    run_op(8'd130, 8'd127, 24'hA00000, 24'hC00000, 0, "diff3");
    run_op(8'd120, 8'd125, 24'h800001, 24'hF00000, 0, "diff5_swap");
    run_op(8'd167, 8'd127, 24'h900000, 24'h800000, 0, "diff40_sat");
    run_op(8'd100, 8'd127, 24'hFFFFFF, 24'h812345, 0, "diff27_edge");
    run_op(8'd128, 8'd127, 24'h800000, 24'hFFFFFF, 0, "diff1");
    run_op(8'd140, 8'd132, 24'hC12345, 24'hB0000F, 5, "backpressure");

    // Reset while the shifter is mid-operation.
    @(negedge clk);
    in_valid  = 1'b1;
    exp_a     = 8'd147;
    exp_b     = 8'd127;
    diff      = 8'd20;
    diff_sign = 1'b0;
    man_a     = 24'hFEDCBA;
    man_b     = 24'hABCDEF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("midshift_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midshift_rst");
    run_op(8'd90, 8'd99, 24'h9ABCDE, 24'hF00001, 0, "after_rst");

    for (int k = 0; k < 30; k++) begin
      ra = EXP_W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) rb = EXP_W'($urandom_range(0, 255));
      else rb = EXP_W'(int'(ra) + $urandom_range(0, 12) - 6);
      run_op(ra, rb, {1'b1, 23'($urandom)}, {1'b1, 23'($urandom)},
             $urandom_range(0, 2), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
